handshake_tracker: RTL
======================

// Module: handshake_tracker
// PURPOSE
//   Parametrised CPU-side to SRAM-like bus handshake adapter with multiple outstanding transactions.
//   Latches a one-cycle CPU request and holds bus req until addr_ok.
//   Counts in-flight transactions and matches in-order data_ok responses to them.
//   On flush, silently discards responses to transactions issued before the flush.
//   Sits between a pipeline stage (fetch or mem) and the I/D bus bridge.
// PARAMETERS
//   ADDR_W   32  address width
//   DATA_W   32  read/write data width
//   MAX_OUT   4  max in-flight transactions (>=1); counters are $clog2(MAX_OUT+1) bits
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       reset, asynchronous, active-high
//   cpu_req    in   1       CPU request valid this cycle
//   cpu_wr     in   1       CPU request is write
//   cpu_addr   in   ADDR_W  CPU request address
//   cpu_wdata  in   DATA_W  CPU write data
//   flush      in   1       discard all responses of already-issued transactions
//   cpu_addr_ok out 1       CPU request accepted this cycle
//   cpu_data_ok out 1       response delivered to CPU this cycle
//   cpu_rdata  out  DATA_W  response data (equals rdata)
//   req        out  1       bus request valid
//   wr         out  1       bus request is write
//   addr       out  ADDR_W  bus address
//   wdata      out  DATA_W  bus write data
//   addr_ok    in   1       bus accepted request (valid only while req=1)
//   data_ok    in   1       bus response valid; responses return in issue order
//   rdata      in   DATA_W  bus response data
//   busy       out  1       req | (cnt != 0)
//   proto_err  out  1       sticky: data_ok received with no transaction in flight
// BEHAVIOUR
//   Reset (async): req=0, wr=0, addr=0, wdata=0, cnt=0, drop=0, proto_err=0.
//   Outputs cpu_addr_ok, cpu_data_ok and busy are combinational from this state.
//   Accept: cpu_addr_ok = cpu_req & ~req & ~flush & (cnt < MAX_OUT).
//   - On accept: req<=1; wr/addr/wdata <= cpu_* at the next edge.
//   - So req rises one cycle after cpu_req; no accept while req=1.
//   Issue: req & addr_ok -> req<=0, cnt+1.
//   - req/wr/addr/wdata are stable until addr_ok; never retracted, including by flush.
//   Response: data_ok & cnt!=0 -> cnt-1.
//   - data_ok & addr_ok in the same cycle -> cnt unchanged.
//   - cnt never exceeds MAX_OUT.
//   Delivery: cpu_data_ok = data_ok & (cnt!=0) & (drop==0); cpu_rdata = rdata.
//   Discard: data_ok & cnt!=0 & drop!=0 -> drop-1; no cpu_data_ok that cycle.
//   Flush (single cycle):
//   - drop <= cnt_next + req_next, i.e. in-flight plus a still-pending request. Max MAX_OUT.
//   - A data_ok in the flush cycle is still delivered (if drop==0) before drop is loaded.
//   - A pending req continues until addr_ok; its response is later dropped.
//   Error: data_ok & cnt==0 -> proto_err<=1, counters unchanged; cleared only by reset.
//   Reset mid-transaction: all state cleared immediately.
//   - The bus side must also be reset; stale data_ok afterwards raises proto_err.
// TESTING
//   Single read: cpu_req@0 addr=0x100 -> cpu_addr_ok@0, req=1 addr=0x100 @1.
//   - Continued: addr_ok@3 -> req=0 @4, cnt=1; data_ok@5 rdata=0xDEAD -> cpu_data_ok@5 cpu_rdata=0xDEAD.
//   Saturation (MAX_OUT=4): 4 issued with no data_ok -> cnt=4, cpu_req held -> cpu_addr_ok=0.
//   - Continued: one data_ok -> cpu_addr_ok=1 next cycle.
//   Simultaneous: cnt=2, addr_ok & data_ok same cycle -> cnt stays 2, cpu_data_ok=1.
//   Flush: cnt=2, req pending, flush -> drop=3.
//   - Continued: next 3 data_ok give cpu_data_ok=0, 4th gives 1.
//   - Continued: during flush cycle cpu_req=1 -> cpu_addr_ok=0.
//   Error/reset: data_ok with cnt=0 -> proto_err=1 next edge, stays set.
//   - Continued: async reset mid-req -> req=0, proto_err=0 without a clock edge.

Source files
------------

// File: rtl/handshake_tracker.sv
// CPU-side to SRAM-like bus handshake adapter with multiple outstanding transactions.
// Holds one bus request until addr_ok, counts in-flight transactions and drops responses on flush.
module handshake_tracker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              flush,
  output logic              cpu_addr_ok,
  output logic              cpu_data_ok,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              req,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              proto_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic              r_req;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_drop;
  logic              r_proto_err;

  logic              w_accept;
  logic              w_issue;
  logic              w_resp;
  logic              w_stray;
  logic              w_req_next;
  logic [CW-1:0]     w_cnt_next;
  logic [CW-1:0]     w_drop_next;

  assign w_accept = cpu_req & ~r_req & ~flush & (r_cnt < MAX_CNT);
  assign w_issue  = r_req & addr_ok;
  assign w_resp   = data_ok & (r_cnt != CNT_ZERO);
  assign w_stray  = data_ok & (r_cnt == CNT_ZERO);

  // Next in-flight count, pending-request flag and discard count
  always_comb begin
    w_cnt_next  = r_cnt;
    w_req_next  = r_req;
    w_drop_next = r_drop;

    case ({w_issue, w_resp})
      2'b10:   w_cnt_next = r_cnt + CNT_ONE;
      2'b01:   w_cnt_next = r_cnt - CNT_ONE;
      default: w_cnt_next = r_cnt;
    endcase

    if (w_accept) begin
      w_req_next = 1'b1;
    end else if (w_issue) begin
      w_req_next = 1'b0;
    end else begin
      w_req_next = r_req;
    end

    // A pending request still counts: its response must be discarded too
    if (flush) begin
      w_drop_next = w_cnt_next + {{(CW-1){1'b0}}, w_req_next};
    end else if (w_resp && (r_drop != CNT_ZERO)) begin
      w_drop_next = r_drop - CNT_ONE;
    end else begin
      w_drop_next = r_drop;
    end
  end

  // Bus request holding registers and transaction bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req       <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_cnt       <= CNT_ZERO;
      r_drop      <= CNT_ZERO;
      r_proto_err <= 1'b0;
    end else begin
      r_req  <= w_req_next;
      r_cnt  <= w_cnt_next;
      r_drop <= w_drop_next;
      if (w_accept) begin
        r_wr    <= cpu_wr;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (w_stray) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign cpu_addr_ok = w_accept;
  assign cpu_data_ok = w_resp & (r_drop == CNT_ZERO);
  assign cpu_rdata   = rdata;
  assign req         = r_req;
  assign wr          = r_wr;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign busy        = r_req | (r_cnt != CNT_ZERO);
  assign proto_err   = r_proto_err;

endmodule
